// File: rtl/mdu_div32_pkg.sv
// Shared types and constants for the multi-cycle MIPS DIV/DIVU divider.
package mdu_div32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_CALC  = 2'b10,
    ST_FIX   = 2'b11
  } div_state_t;

  // is_signed encoding: DIV when high, DIVU when low
  localparam logic SEL_DIV = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 32'd1) ? $clog2(w) : 32'd1;
  endfunction

endpackage

// File: rtl/mdu_div32_step.sv
// One restoring shift-subtract iteration; the FSM in mdu_div32 reuses this instance every cycle.
module mdu_div32_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);

  logic [WIDTH:0] partial_s;
  logic [WIDTH:0] trial_s;
  logic           borrow_s;

  // Because rem < div always holds, the MSB of the WIDTH+1-bit difference is exactly the borrow.
  always_comb begin
    partial_s = {rem, quo[WIDTH-1]};
    trial_s   = partial_s - {1'b0, div};
    borrow_s  = trial_s[WIDTH];
    if (borrow_s) begin
      rem_n = partial_s[WIDTH-1:0];
    end else begin
      rem_n = trial_s[WIDTH-1:0];
    end
    quo_n = {quo[WIDTH-2:0], ~borrow_s};
  end

endmodule

// File: rtl/mdu_div32.sv
// Multi-cycle signed/unsigned divider: SETUP takes magnitudes, CALC runs WIDTH restoring steps,
// FIX presents sign-corrected quotient (LO) and remainder (HI) with a one-cycle done pulse.
module mdu_div32
  import mdu_div32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned            CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]       CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0]       W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]       W_ONES   = {WIDTH{1'b1}};

  div_state_t       state_r, state_s;
  logic             accept_s;
  logic             dvs_zero_s;
  logic             last_step_s;

  logic [WIDTH-1:0] dvd_raw_r, dvs_raw_r;
  logic             signed_r;
  logic [WIDTH-1:0] rem_r, quo_r, div_r;
  logic             neg_q_r, neg_r_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] dvd_abs_s, dvs_abs_s;
  logic [WIDTH-1:0] rem_n_s, quo_n_s;
  logic [WIDTH-1:0] q_fix_s, r_fix_s;

  logic             busy_r, done_r, dbz_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;

  mdu_div32_step #(.WIDTH(WIDTH)) u_step (
    .rem   (rem_r),
    .quo   (quo_r),
    .div   (div_r),
    .rem_n (rem_n_s),
    .quo_n (quo_n_s)
  );

  // Next-state decode; FIX also accepts a new start so divides can run back to back.
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    dvs_zero_s  = (dvs_raw_r == W_ZERO);
    last_step_s = (cnt_r == CNT_ZERO);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = ST_SETUP;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (dvs_zero_s) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_CALC: begin
        if (last_step_s) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_FIX: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = ST_SETUP;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Magnitudes of the captured operands and sign correction of the final step result.
  always_comb begin
    if (signed_r && dvd_raw_r[WIDTH-1]) begin
      dvd_abs_s = -dvd_raw_r;
    end else begin
      dvd_abs_s = dvd_raw_r;
    end
    if (signed_r && dvs_raw_r[WIDTH-1]) begin
      dvs_abs_s = -dvs_raw_r;
    end else begin
      dvs_abs_s = dvs_raw_r;
    end
    if (neg_q_r) begin
      q_fix_s = -quo_n_s;
    end else begin
      q_fix_s = quo_n_s;
    end
    if (neg_r_r) begin
      r_fix_s = -rem_n_s;
    end else begin
      r_fix_s = rem_n_s;
    end
  end

  // State register plus registered busy/done derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_FIX);
    end
  end

  // Operand capture, magnitude setup and the iterated shift-subtract datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_raw_r <= W_ZERO;
      dvs_raw_r <= W_ZERO;
      signed_r  <= 1'b0;
      rem_r     <= W_ZERO;
      quo_r     <= W_ZERO;
      div_r     <= W_ZERO;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      cnt_r     <= CNT_ZERO;
    end else begin
      if (accept_s) begin
        dvd_raw_r <= dividend;
        dvs_raw_r <= divisor;
        signed_r  <= (is_signed == SEL_DIV);
      end else begin
        dvd_raw_r <= dvd_raw_r;
      end
      case (state_r)
        ST_SETUP: begin
          rem_r   <= W_ZERO;
          quo_r   <= dvd_abs_s;
          div_r   <= dvs_abs_s;
          neg_q_r <= signed_r & (dvd_raw_r[WIDTH-1] ^ dvs_raw_r[WIDTH-1]);
          neg_r_r <= signed_r & dvd_raw_r[WIDTH-1];
          cnt_r   <= CNT_LAST;
        end
        ST_CALC: begin
          rem_r <= rem_n_s;
          quo_r <= quo_n_s;
          cnt_r <= cnt_r - CNT_W'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Result registers load only on the edge entering FIX, so they are stable otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quotient_r  <= W_ZERO;
      remainder_r <= W_ZERO;
      dbz_r       <= 1'b0;
    end else if ((state_r == ST_SETUP) && dvs_zero_s) begin
      quotient_r  <= W_ONES;
      remainder_r <= dvd_raw_r;
      dbz_r       <= 1'b1;
    end else if ((state_r == ST_CALC) && last_step_s) begin
      quotient_r  <= q_fix_s;
      remainder_r <= r_fix_s;
      dbz_r       <= 1'b0;
    end else begin
      quotient_r  <= quotient_r;
      remainder_r <= remainder_r;
      dbz_r       <= dbz_r;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_mdu_div32.sv
// Directed plus random checks of mdu_div32 against an arithmetic reference model.
module tb_mdu_div32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  mdu_div32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; truncating division and dividend-signed remainder.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, q64, r64;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else begin
      sa  = s ? longint'($signed(a)) : longint'(a);
      sb  = s ? longint'($signed(b)) : longint'(b);
      q64 = sa / sb;
      r64 = sa % sb;
      q   = q64[31:0];
      r   = r64[31:0];
      z   = 1'b0;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 80);
  endtask

  task automatic check_res(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s);
    logic [31:0] eq, er;
    logic        ez;
    ref_div(a, b, s, eq, er, ez);
    chk({tag, ".q"}, quotient, eq);
    chk({tag, ".r"}, remainder, er);
    chk({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  // Called idle at #1 after an edge; edges counted after the accepting edge (33 normal, 1 for /0).
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input string tag);
    int n;
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom;
    wait_done(n);
    chk({tag, ".lat"}, n, (b == 32'd0) ? 32'd1 : 32'd33);
    chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd1);
    check_res(tag, a, b, s);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n, n2, cnt;
    logic [31:0] a, b;
    logic        s;
    int          sel;

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.q", quotient, 32'd0);
    chk("rst.r", remainder, 32'd0);
    chk("rst.dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_div(32'd100, 32'd7, 1'b0, "u100_7");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7_2");
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, "s7_-2");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1");
    do_div(32'h0000_1234, 32'd0, 1'b0, "dbz");
    do_div(32'h8000_0000, 32'd0, 1'b1, "dbz_s");
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_ones");
    do_div(32'd3, 32'h8000_0001, 1'b0, "u_small");

    // start pulsed while busy must be ignored
    dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    dividend = 32'd55; divisor = 32'd5; is_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("ign.lat", n + 5, 32'd33);
    check_res("ign", 32'd1000, 32'd3, 1'b0);
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (done) cnt++; end
    chk("ign.extra_done", cnt, 32'd0);

    // back-to-back with start held through done
    dividend = 32'hDEAD_BEEF; divisor = 32'd17; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    wait_done(n);
    chk("b2b.lat1", n, 32'd33);
    check_res("b2b1", 32'hDEAD_BEEF, 32'd17, 1'b0);
    dividend = 32'hC000_0001; divisor = 32'd9; is_signed = 1'b1;
    n2 = 0;
    do begin @(posedge clk); #1; n2++; end while (!(done && n2 > 1) && n2 < 80);
    start = 1'b0;
    chk("b2b.gap", n2, 32'd34);
    check_res("b2b2", 32'hC000_0001, 32'd9, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // reset in the middle of a divide
    dividend = 32'd999; divisor = 32'd4; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst.busy", {31'd0, busy}, 32'd0);
    chk("mrst.done", {31'd0, done}, 32'd0);
    chk("mrst.q", quotient, 32'd0);
    chk("mrst.r", remainder, 32'd0);
    chk("mrst.dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (50) begin @(posedge clk); #1; if (done || busy) cnt++; end
    chk("mrst.no_done", cnt, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      a   = $urandom;
      b   = $urandom;
      s   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 15);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) a = 32'h8000_0000;
      else if (sel == 2) b = 32'hFFFF_FFFF;
      else if (sel == 3) b = $urandom_range(1, 15);
      else if (sel == 4) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      do_div(a, b, s, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
